// File: rtl/cxd2545_pkg.sv
// Shared definitions for the CXD2545 SubQ channel: reader FSM states,
// frame geometry and the serial CRC-16-CCITT step used on both sides.
package cxd2545_pkg;

  // Reader FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } subq_state_e;

  // Frame geometry: 80 Q data bits followed by a 16-bit (inverted) CRC
  localparam int          SUBQ_NBITS     = 96;
  localparam int          SUBQ_DATA_BITS = 80;
  localparam logic [15:0] CRC16_POLY     = 16'h1021;

  // One serial, MSB-first, non-reflected CRC-16-CCITT step
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cxd2545_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator (poly 0x1021, init 0, non-reflected).
// One bit per enabled cycle; clear takes priority over enable.
module cxd2545_crc16_serial
  import cxd2545_pkg::*;
(
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_r;

  // CRC register: reset/clear to zero, otherwise fold in one bit when enabled
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      crc_r <= 16'h0000;
    end else if (clear) begin
      crc_r <= 16'h0000;
    end else if (enable) begin
      crc_r <= crc16_step(crc_r, bit_in);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc_out = crc_r;

endmodule

// File: rtl/cxd2545_subq_reader.sv
// Host-side SubQ reader for the CXD2545 serial channel. On each SCOR rising
// edge it clocks SQCK 96 times, shifts in 80 Q bits plus the 16-bit inverted
// CRC, checks the CRC and presents the frame with a one-cycle frame_valid.
module cxd2545_subq_reader
  import cxd2545_pkg::*;
#(
  parameter int HALF_PERIOD = 25,
  parameter int SYNC_STAGES = 2,
  parameter int NBITS       = 96
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        scor,
  input  logic        subq,
  output logic        sqck,
  output logic        busy,
  output logic [79:0] q_data,
  output logic [15:0] crc_rx,
  output logic        crc_ok,
  output logic        frame_valid,
  output logic [7:0]  missed_scor
);

  // Half-period counter runs 0..HALF_PERIOD-1
  localparam int              HC_W          = $clog2(HALF_PERIOD);
  localparam logic [HC_W-1:0] HC_LAST       = HC_W'(HALF_PERIOD - 1);
  localparam logic [6:0]      BIT_LAST      = 7'(NBITS - 1);
  localparam logic [6:0]      BIT_DATA_LAST = 7'(SUBQ_DATA_BITS - 1);

  // Synchronisers and edge detect
  logic [SYNC_STAGES-1:0] scor_sync_r;
  logic [SYNC_STAGES-1:0] subq_sync_r;
  logic                   scor_prev_r;
  logic                   scor_s;
  logic                   subq_s;
  logic                   scor_rise_s;

  // FSM
  subq_state_e            state_r;
  subq_state_e            state_s;
  logic [HC_W-1:0]        half_cnt_r;
  logic [HC_W-1:0]        half_cnt_s;
  logic [6:0]             bit_cnt_r;
  logic [6:0]             bit_cnt_s;
  logic                   sample_s;
  logic                   crc_clear_s;
  logic                   crc_en_s;

  // Datapath
  logic [NBITS-1:0]       shreg_r;
  logic [15:0]            crc_calc_s;

  // Registered outputs
  logic                   sqck_r;
  logic                   busy_r;
  logic [79:0]            q_data_r;
  logic [15:0]            crc_rx_r;
  logic                   crc_ok_r;
  logic                   frame_valid_r;
  logic [7:0]             missed_r;

  // Bring scor/subq into the sclk domain and keep a delayed scor for edge detect
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      scor_sync_r <= '0;
      subq_sync_r <= '0;
      scor_prev_r <= 1'b0;
    end else begin
      scor_sync_r <= {scor_sync_r[SYNC_STAGES-2:0], scor};
      subq_sync_r <= {subq_sync_r[SYNC_STAGES-2:0], subq};
      scor_prev_r <= scor_sync_r[SYNC_STAGES-1];
    end
  end

  assign scor_s      = scor_sync_r[SYNC_STAGES-1];
  assign subq_s      = subq_sync_r[SYNC_STAGES-1];
  assign scor_rise_s = scor_s & ~scor_prev_r;

  // Next-state logic: SQCK low/high phases, sample at the end of each low phase
  always_comb begin
    state_s     = state_r;
    half_cnt_s  = half_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    sample_s    = 1'b0;
    crc_clear_s = 1'b0;
    crc_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (scor_rise_s && enable) begin
          state_s     = LOW;
          half_cnt_s  = '0;
          bit_cnt_s   = 7'd0;
          crc_clear_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOW: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (half_cnt_r == HC_LAST) begin
          // Last low cycle: take the bit; only Q data bits feed the CRC
          sample_s   = 1'b1;
          crc_en_s   = (bit_cnt_r <= BIT_DATA_LAST);
          half_cnt_s = '0;
          state_s    = HIGH;
        end else begin
          half_cnt_s = half_cnt_r + 1'b1;
        end
      end
      HIGH: begin
        if (!enable) begin
          state_s = IDLE;
        end else if (half_cnt_r == HC_LAST) begin
          half_cnt_s = '0;
          if (bit_cnt_r == BIT_LAST) begin
            state_s = DONE;
          end else begin
            bit_cnt_s = bit_cnt_r + 7'd1;
            state_s   = LOW;
          end
        end else begin
          half_cnt_s = half_cnt_r + 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      half_cnt_r <= '0;
      bit_cnt_r  <= 7'd0;
    end else begin
      state_r    <= state_s;
      half_cnt_r <= half_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
    end
  end

  // Frame shift register: first received bit ends up in the MSB
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      shreg_r <= '0;
    end else if (sample_s) begin
      shreg_r <= {shreg_r[NBITS-2:0], subq_s};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  cxd2545_crc16_serial u_crc (
    .sclk    (sclk),
    .reset_n (reset_n),
    .clear   (crc_clear_s),
    .enable  (crc_en_s),
    .bit_in  (subq_s),
    .crc_out (crc_calc_s)
  );

  // Output registers: derived from the next state so they line up with state_r
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      sqck_r        <= 1'b1;
      busy_r        <= 1'b0;
      frame_valid_r <= 1'b0;
      q_data_r      <= 80'h0;
      crc_rx_r      <= 16'h0000;
      crc_ok_r      <= 1'b0;
    end else begin
      sqck_r        <= (state_s != LOW);
      busy_r        <= (state_s != IDLE);
      frame_valid_r <= (state_s == DONE);
      if (state_s == DONE) begin
        // The transmitted CRC is inverted, so a good frame has crc == ~field
        q_data_r <= shreg_r[NBITS-1:16];
        crc_rx_r <= shreg_r[15:0];
        crc_ok_r <= (crc_calc_s == ~shreg_r[15:0]);
      end else begin
        q_data_r <= q_data_r;
        crc_rx_r <= crc_rx_r;
        crc_ok_r <= crc_ok_r;
      end
    end
  end

  // Saturating count of SCOR edges that arrive while a frame is in progress
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      missed_r <= 8'd0;
    end else if (scor_rise_s && (state_r != IDLE) && (missed_r != 8'hFF)) begin
      missed_r <= missed_r + 8'd1;
    end else begin
      missed_r <= missed_r;
    end
  end

  assign sqck        = sqck_r;
  assign busy        = busy_r;
  assign q_data      = q_data_r;
  assign crc_rx      = crc_rx_r;
  assign crc_ok      = crc_ok_r;
  assign frame_valid = frame_valid_r;
  assign missed_scor = missed_r;

endmodule

// File: tb/tb_cxd2545_subq_reader.sv
// Self-checking bench for cxd2545_subq_reader: a SubQ source model that shifts
// a frame out on SQCK falling edges, a CRC reference by polynomial division,
// and scenario tasks for good/bad frames, overrun, abort and mid-frame reset.
module tb_cxd2545_subq_reader;

  logic        sclk;
  logic        reset_n;
  logic        enable;
  logic        scor;
  logic        subq;
  logic        sqck;
  logic        busy;
  logic [79:0] q_data;
  logic [15:0] crc_rx;
  logic        crc_ok;
  logic        frame_valid;
  logic [7:0]  missed_scor;

  cxd2545_subq_reader #(.HALF_PERIOD(25), .SYNC_STAGES(2), .NBITS(96)) dut (
    .sclk        (sclk),
    .reset_n     (reset_n),
    .enable      (enable),
    .scor        (scor),
    .subq        (subq),
    .sqck        (sqck),
    .busy        (busy),
    .q_data      (q_data),
    .crc_rx      (crc_rx),
    .crc_ok      (crc_ok),
    .frame_valid (frame_valid),
    .missed_scor (missed_scor)
  );

  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor / source-model state
  logic [95:0] tx_bits = '0;
  int cyc = 0, fall_cnt = 0, fv_cnt = 0;
  int last_fall = 0, min_per = 0, max_per = 0, first_lat = 0, scor_cyc = 0;
  logic sqck_q = 1'b1, scor_q = 1'b0;

  // Expected sticky outputs
  logic [79:0] last_q = '0;
  logic [15:0] last_crc = '0;
  logic        last_ok = 1'b0;
  int          missed_exp = 0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference CRC: remainder of Q(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] crc_model(input logic [79:0] q);
    logic [95:0] r;
    r = {q, 16'h0000};
    for (int i = 95; i >= 16; i--) begin
      if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  // Sampling away from the active edge: count SQCK falls, measure period,
  // and present the next frame bit on each fall like the drive would
  initial begin
    forever begin
      @(negedge sclk);
      cyc++;
      if (scor && !scor_q && fall_cnt == 0) scor_cyc = cyc;
      if (!sqck && sqck_q) begin
        if (fall_cnt > 0) begin
          if (cyc - last_fall < min_per) min_per = cyc - last_fall;
          if (cyc - last_fall > max_per) max_per = cyc - last_fall;
        end else begin
          first_lat = cyc - scor_cyc;
        end
        last_fall = cyc;
        if (fall_cnt < 96) subq = tx_bits[95 - fall_cnt];
        fall_cnt++;
      end
      if (frame_valid) fv_cnt++;
      sqck_q = sqck;
      scor_q = scor;
    end
  end

  // One frame scenario: optional Q/CRC corruption, extra SCOR pulses at given
  // bits, a burst of overlapping pulses, or an abort/reset at a given bit
  task automatic run_frame(input logic [79:0] q, input int flip_q, input int flip_crc,
                           input int p1, input int p2, input int n_burst,
                           input int abort_at, input int rst_at);
    logic [95:0] tx;
    logic        ok_exp;
    int          since, bursts, waited;
    bit          d1, d2, stopped, want;
    tx = {q, ~crc_model(q)};
    if (flip_q >= 0) tx[16 + flip_q] = ~tx[16 + flip_q];
    if (flip_crc >= 0) tx[flip_crc] = ~tx[flip_crc];
    ok_exp = (tx[15:0] == ~crc_model(tx[95:16]));
    tx_bits = tx;
    fall_cnt = 0; fv_cnt = 0; min_per = 9999; max_per = 0; first_lat = 9999;
    since = 0; bursts = 0; waited = 0; d1 = 0; d2 = 0; stopped = 0;
    @(posedge sclk); #2;
    scor = 1'b1;
    while (fv_cnt == 0 && !stopped && waited < 6000) begin
      @(negedge sclk);
      waited++;
      since++;
      if (since == 4) scor = 1'b0;
      if (since >= 8) begin
        want = 0;
        if (p1 >= 0 && !d1 && fall_cnt == p1 + 1) begin d1 = 1; want = 1; end
        else if (p2 >= 0 && !d2 && fall_cnt == p2 + 1) begin d2 = 1; want = 1; end
        else if (bursts < n_burst && fall_cnt >= 2 && fall_cnt < 90) begin bursts++; want = 1; end
        if (want) begin
          scor = 1'b1;
          since = 0;
          if (missed_exp < 255) missed_exp++;
        end
      end
      if (abort_at >= 0 && fall_cnt == abort_at + 1) begin
        enable = 1'b0;
        scor = 1'b0;
        @(negedge sclk);
        check_eq("abort_sqck", 96'(sqck), 96'd1);
        check_eq("abort_busy", 96'(busy), 96'd0);
        repeat (300) @(negedge sclk);
        check_eq("abort_no_fv", 96'(fv_cnt), 96'd0);
        check_eq("abort_q_hold", 96'(q_data), 96'(last_q));
        check_eq("abort_ok_hold", 96'(crc_ok), 96'(last_ok));
        enable = 1'b1;
        stopped = 1;
      end else if (rst_at >= 0 && fall_cnt == rst_at + 1) begin
        reset_n = 1'b0;
        scor = 1'b0;
        @(negedge sclk);
        check_eq("rst_sqck", 96'(sqck), 96'd1);
        check_eq("rst_busy", 96'(busy), 96'd0);
        check_eq("rst_fv", 96'(frame_valid), 96'd0);
        check_eq("rst_q", 96'(q_data), 96'd0);
        check_eq("rst_crc_rx", 96'(crc_rx), 96'd0);
        check_eq("rst_crc_ok", 96'(crc_ok), 96'd0);
        check_eq("rst_missed", 96'(missed_scor), 96'd0);
        last_q = '0; last_crc = '0; last_ok = 1'b0; missed_exp = 0;
        repeat (3) @(negedge sclk);
        reset_n = 1'b1;
        repeat (3) @(negedge sclk);
        check_eq("rst_no_fv", 96'(fv_cnt), 96'd0);
        stopped = 1;
      end
    end
    scor = 1'b0;
    if (!stopped) begin
      repeat (5) @(negedge sclk);
      check_eq("fv_count", 96'(fv_cnt), 96'd1);
      check_eq("fall_count", 96'(fall_cnt), 96'd96);
      check_eq("period_min", 96'(min_per), 96'd50);
      check_eq("period_max", 96'(max_per), 96'd50);
      check_eq("first_fall_le4", 96'(first_lat <= 4), 96'd1);
      check_eq("q_data", 96'(q_data), 96'(tx[95:16]));
      check_eq("crc_rx", 96'(crc_rx), 96'(tx[15:0]));
      check_eq("crc_ok", 96'(crc_ok), 96'(ok_exp));
      check_eq("missed", 96'(missed_scor), 96'(missed_exp));
      check_eq("idle_busy", 96'(busy), 96'd0);
      last_q = tx[95:16]; last_crc = tx[15:0]; last_ok = ok_exp;
    end
  endtask

  initial begin
    logic [79:0] rq;
    int          fc;
    reset_n = 1'b0; enable = 1'b1; scor = 1'b0; subq = 1'b0;
    repeat (3) @(posedge sclk);
    #2 reset_n = 1'b1;
    @(negedge sclk);
    check_eq("reset_sqck", 96'(sqck), 96'd1);
    check_eq("reset_busy", 96'(busy), 96'd0);
    check_eq("reset_fv", 96'(frame_valid), 96'd0);
    check_eq("reset_missed", 96'(missed_scor), 96'd0);
    check_eq("reset_q", 96'(q_data), 96'd0);
    check_eq("reset_crc_ok", 96'(crc_ok), 96'd0);
    fall_cnt = 0;
    repeat (10000) @(negedge sclk);
    check_eq("idle_no_falls", 96'(fall_cnt), 96'd0);
    check_eq("idle_sqck", 96'(sqck), 96'd1);

    // SCOR while disabled starts nothing and is not counted as missed
    enable = 1'b0;
    @(posedge sclk); #2 scor = 1'b1;
    repeat (4) @(negedge sclk);
    scor = 1'b0;
    repeat (100) @(negedge sclk);
    check_eq("dis_no_falls", 96'(fall_cnt), 96'd0);
    check_eq("dis_busy", 96'(busy), 96'd0);
    check_eq("dis_missed", 96'(missed_scor), 96'd0);
    enable = 1'b1;
    repeat (10) @(negedge sclk);

    // Good frame, then the same frame with Q bit 40 flipped
    run_frame(80'h41010100000000000200, -1, -1, -1, -1, 0, -1, -1);
    run_frame(80'h41010100000000000200, 40, -1, -1, -1, 0, -1, -1);
    // Overrun at bits 30 and 60, then a burst that saturates the counter
    run_frame({$urandom, $urandom, 16'($urandom)}, -1, -1, 30, 60, 0, -1, -1);
    run_frame({$urandom, $urandom, 16'($urandom)}, -1, -1, -1, -1, 300, -1, -1);
    // Abort at bit 40, then a fresh frame
    run_frame({$urandom, $urandom, 16'($urandom)}, -1, -1, -1, -1, 0, 40, -1);
    repeat (20) @(negedge sclk);
    run_frame({$urandom, $urandom, 16'($urandom)}, -1, -1, -1, -1, 0, -1, -1);
    // Reset at bit 50, then a fresh frame
    run_frame({$urandom, $urandom, 16'($urandom)}, -1, -1, -1, -1, 0, -1, 50);
    repeat (20) @(negedge sclk);
    run_frame({$urandom, $urandom, 16'($urandom)}, -1, -1, -1, -1, 0, -1, -1);
    // Random frames, some with a corrupted CRC field
    for (int k = 0; k < 3; k++) begin
      rq = {$urandom, $urandom, 16'($urandom)};
      fc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      repeat (20) @(negedge sclk);
      run_frame(rq, -1, fc, -1, -1, 0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
